instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the instruction interface that feeds the controller/decoder.
//  Fetches 32-bit words from instruction memory over a req/ack handshake, buffers
//  them in a small prefetch FIFO, and presents one instruction per accepted beat.
//  Accepts PC redirects (PCSrc + target) from the execute side, then flushes and refetches.
// PARAMETERS
//  DEPTH    4             prefetch FIFO entries; power of 2, >=2
//  RESET_PC 32'h0000_0000 first fetch address after reset; word-aligned
// PORTS
//  clk           in  1   clock, rising edge
//  reset         in  1   asynchronous, active-high
//  imem_req      out 1   fetch request; held until imem_ack
//  imem_addr     out 32  fetch address; stable while imem_req=1; bits[1:0]=0
//  imem_ack      in  1   1-cycle response strobe; imem_rdata valid same cycle
//  imem_rdata    in  32  fetched word
//  instr_valid   out 1   FIFO head valid
//  instr_ready   in  1   consumer accepts head this cycle
//  instr         out 32  head instruction word (Cond/Op/Funct/Rd fields intact)
//  instr_pc      out 32  address of head instruction
//  pcsrc         in  1   redirect strobe (branch taken / write to R15)
//  pc_target     in  32  redirect address; bits[1:0] ignored, forced 0
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0,
//   imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//  FSM (imem_req=1 in REQ and DROP; imem_addr=fetch_pc):
//   IDLE: pcsrc -> fetch_pc<=target, stay IDLE; else if count<DEPTH -> REQ.
//   REQ : ack&!pcsrc -> push {rdata,fetch_pc}, fetch_pc+=4, -> IDLE.
//         ack&pcsrc  -> discard rdata, fetch_pc<=target, -> IDLE.
//         !ack&pcsrc -> fetch_pc_next<=target, -> DROP (old request stays up).
//         else stay REQ.
//   DROP: ack -> discard rdata, fetch_pc<=fetch_pc_next, -> IDLE;
//         pcsrc in DROP overwrites fetch_pc_next (latest target wins).
//  imem_addr never changes while imem_req=1; at most one request outstanding.
//  FIFO: push only from REQ on ack; pop when instr_valid&instr_ready.
//   Push and pop in the same cycle both occur; count unchanged.
//   Never overflows: a request is only issued when count<DEPTH.
//   Read/write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  pcsrc: FIFO cleared on the next edge; a same-cycle pop or push is dropped;
//   instr_valid=0 the cycle after pcsrc.
//  Latency: IDLE->REQ 1 cycle; ack at cycle n -> instr_valid at n+1 (registered head).
//   Zero-wait memory sustains 1 instr / 2 cycles.
//  instr/instr_pc hold the last value while instr_valid=0; do not care for the consumer.
//  fetch_pc+4 wraps 32'hFFFF_FFFC -> 0 with no error.
//  Reset mid-request: imem_req drops asynchronously; a late ack after reset is
//   ignored (state IDLE).
// TESTING
//  1 Reset, zero-wait mem, ready=1 -> addrs 0,4,8,..; instr_pc tracks; no gaps in order.
//  2 ready=0, DEPTH=4 -> exactly 4 acks, then imem_req stays 0; ready=1 pops 4
//    in order and fetching resumes at 0x10.
//  3 pcsrc with target 0x100 while REQ pending (ack 3 cycles later) -> old addr held
//    until ack, data dropped, next req addr=0x100, FIFO empty in between.
//  4 pcsrc in same cycle as ack -> word not pushed; next req=target; FIFO empty.
//  5 pcsrc with target 0x203 -> fetch at 0x200; pcsrc twice in DROP (0x40, 0x80) -> 0x80.
//  6 Assert reset with req pending and FIFO holding 3 entries -> all outputs at reset
//    values immediately; first req at RESET_PC 1 cycle after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with prefetch FIFO and PC redirect
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        pcsrc,
    input  logic [31:0] pc_target
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state, state_nx;
    logic [31:0]    fetch_pc, fetch_pc_nx;
    logic [31:0]    drop_pc, drop_pc_nx;
    logic [31:0]    target;
    logic           push, pop;
    logic [AW:0]    count, count_nx;
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
    logic [31:0]    mem_data [DEPTH];
    logic [31:0]    mem_pc   [DEPTH];
    logic [31:0]    head_data_nx, head_pc_nx;
    logic           unused_bits;

    assign target      = {pc_target[31:2], 2'b00};
    assign unused_bits = ^pc_target[1:0];
    assign imem_req    = (state == REQ) || (state == DROP);
    assign imem_addr   = fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop_pc  <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            drop_pc  <= drop_pc_nx;
        end
    end

    // The outstanding request is never withdrawn; a redirect while it is pending
    // parks the target in drop_pc until the stale response arrives.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_pc_nx  = drop_pc;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (pcsrc)
                    fetch_pc_nx = target;
                else if (count < CNT_FULL)
                    state_nx = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    state_nx = IDLE;
                    if (pcsrc) begin
                        fetch_pc_nx = target;
                    end else begin
                        push        = 1'b1;
                        fetch_pc_nx = fetch_pc + 32'd4;
                    end
                end else if (pcsrc) begin
                    drop_pc_nx = target;
                    state_nx   = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nx    = IDLE;
                    fetch_pc_nx = pcsrc ? target : drop_pc;
                end else if (pcsrc) begin
                    drop_pc_nx = target;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pop = instr_valid & instr_ready & ~pcsrc;

    // Head is registered; when the FIFO would otherwise be empty the incoming
    // word bypasses storage so ack-to-valid stays one cycle.
    always_comb begin
        rd_ptr_nx    = pcsrc ? wr_ptr : rd_ptr + AW'(pop);
        count_nx     = pcsrc ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        head_data_nx = instr;
        head_pc_nx   = instr_pc;
        if (count_nx != '0) begin
            if (count == (AW+1)'(pop)) begin
                head_data_nx = imem_rdata;
                head_pc_nx   = fetch_pc;
            end else begin
                head_data_nx = mem_data[rd_ptr_nx];
                head_pc_nx   = mem_pc[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            count       <= count_nx;
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr_nx;
            instr_valid <= (count_nx != '0);
            instr       <= head_data_nx;
            instr_pc    <= head_pc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        pcsrc;
    logic [31:0] pc_target;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .pcsrc(pcsrc), .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tgt;
        int          lat;
        logic [31:0] e0;
        logic [31:0] e1;
    } redir_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_req, prev_ack, drop_pending;
    int          mem_lat, req_age, ack_cnt, pops;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        req_log.delete();
        exp_pc       = RESET_PC;
        prev_req     = 1'b0;
        prev_ack     = 1'b0;
        prev_addr    = '0;
        drop_pending = 1'b0;
        req_age      = 0;
        ack_cnt      = 0;
        pops         = 0;
    endtask

    task automatic reset_dut();
        imem_ack = 1'b0;
        pcsrc    = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Called at posedge+1: observe, drive the memory/redirect for the next edge, update the model.
    task automatic step(input logic do_pcsrc, input logic [31:0] tgt);
        logic new_req;
        logic [63:0] e;
        new_req = imem_req && !(prev_req && !prev_ack);
        chk("valid_vs_model", instr_valid, (exp_q.size() != 0));
        if (imem_req && !new_req) chk("addr_stable", imem_addr, prev_addr);
        if (new_req) begin
            chk("req_addr", imem_addr, exp_pc);
            req_log.push_back(imem_addr);
            req_age = 0;
        end else if (imem_req) begin
            req_age++;
        end
        imem_ack   = imem_req && (req_age >= mem_lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
        pcsrc      = do_pcsrc;
        pc_target  = tgt;
        if (instr_valid && instr_ready && !do_pcsrc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("instr", instr, e[63:32]);
                chk("instr_pc", instr_pc, e[31:0]);
            end
            pops++;
        end
        if (imem_ack) begin
            if (!do_pcsrc && !drop_pending) begin
                exp_q.push_back({imem_rdata, imem_addr});
                exp_pc = imem_addr + 32'd4;
                ack_cnt++;
            end
            drop_pending = 1'b0;
        end else if (do_pcsrc && imem_req) begin
            drop_pending = 1'b1;
        end
        if (do_pcsrc) begin
            exp_q.delete();
            exp_pc = {tgt[31:2], 2'b00};
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        @(posedge clk); #1;
        if (do_pcsrc) chk("valid_after_pcsrc", instr_valid, 1'b0);
        imem_ack = 1'b0;
        pcsrc    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) step(1'b0, 32'h0);
        chk("wait_req", imem_req, 1'b1);
    endtask

    redir_t tab[3];
    int     n0;

    initial begin
        tab[0] = '{tgt: 32'h0000_0203, lat: 2, e0: 32'h0000_0200, e1: 32'h0000_0204};
        tab[1] = '{tgt: 32'hFFFF_FFFC, lat: 0, e0: 32'hFFFF_FFFC, e1: 32'h0000_0000};
        tab[2] = '{tgt: 32'h0000_1001, lat: 1, e0: 32'h0000_1000, e1: 32'h0000_1004};

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b1;
        pcsrc       = 1'b0;
        pc_target   = '0;
        mem_lat     = 0;
        model_clear();
        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // zero-wait memory, consumer always ready
        reset_dut();
        run(40);
        chk("t1_pops", pops, 19);
        for (int i = 0; i < 8; i++) chk("t1_seq_addr", req_log[i], 32'(i * 4));

        // consumer stalled: FIFO fills to DEPTH, then drains and fetching resumes
        reset_dut();
        instr_ready = 1'b0;
        run(30);
        chk("t2_acks", ack_cnt, 4);
        chk("t2_req_idle", imem_req, 1'b0);
        chk("t2_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        run(12);
        chk("t2_resume_addr", req_log[4], 32'h0000_0010);

        // redirect while a slow request is outstanding
        reset_dut();
        mem_lat = 3;
        wait_req();
        step(1'b1, 32'h0000_0100);
        n0 = req_log.size();
        run(12);
        chk("t3_redir_addr", req_log[n0], 32'h0000_0100);

        // redirect in the same cycle as the ack
        mem_lat = 0;
        wait_req();
        step(1'b1, 32'h0000_0300);
        n0 = req_log.size();
        run(10);
        chk("t4_redir_addr", req_log[n0], 32'h0000_0300);

        // table of redirect targets: alignment and address wrap
        foreach (tab[k]) begin
            mem_lat = tab[k].lat;
            wait_req();
            step(1'b1, tab[k].tgt);
            n0 = req_log.size();
            run(14);
            chk("t5_first_addr", req_log[n0], tab[k].e0);
            chk("t5_next_addr", req_log[n0 + 1], tab[k].e1);
        end

        // two redirects while parked in DROP: the later one wins
        mem_lat = 4;
        wait_req();
        step(1'b1, 32'h0000_0040);
        n0 = req_log.size();
        step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0080);
        run(12);
        chk("t5_drop_latest", req_log[n0], 32'h0000_0080);

        // reset with a request pending and three entries buffered
        reset_dut();
        instr_ready = 1'b0;
        mem_lat     = 2;
        for (int i = 0; i < 40 && !(exp_q.size() == 3 && imem_req); i++) step(1'b0, 32'h0);
        chk("t6_setup_req", imem_req, 1'b1);
        chk("t6_setup_valid", instr_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_req", imem_req, 1'b0);
        chk("t6_async_addr", imem_addr, RESET_PC);
        chk("t6_async_valid", instr_valid, 1'b0);
        chk("t6_async_instr", instr, 32'h0);
        chk("t6_async_instr_pc", instr_pc, 32'h0);
        @(posedge clk); #1;
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("t6_first_req", imem_req, 1'b1);
        chk("t6_first_addr", imem_addr, RESET_PC);
        chk("t6_late_ack_ignored", instr_valid, 1'b0);
        model_clear();
        instr_ready = 1'b1;
        mem_lat     = 0;
        run(16);
        chk("t6_resume_pops", (pops >= 6), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
